// File: rtl/test_status_monitor.sv
// Run/pass/fail/timeout monitor for per-channel test status CSR writes.
// A run completes once every channel has posted a final status word with bit 0 set.
module test_status_monitor #(
  parameter int NUM_CH         = 1,
  parameter int TIMEOUT_CYCLES = 2000,
  parameter int CNT_W          = 32
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [NUM_CH-1:0]                          csr_we,
  input  logic [32*NUM_CH-1:0]                       csr_wdata,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       pass,
  output logic                                       timed_out,
  output logic [30:0]                                fail_code,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] fail_ch,
  output logic [NUM_CH-1:0]                          ch_done,
  output logic [CNT_W-1:0]                           cycles
);

  localparam int FCH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

  state_t            state;
  logic [30:0]       code    [NUM_CH];
  logic [30:0]       code_nx [NUM_CH];
  logic [NUM_CH-1:0] done_nx;
  logic              all_done;
  logic              any_fail;
  logic [FCH_W-1:0]  fch_nx;
  logic [30:0]       fcode_nx;

  // Next-edge view of completions, so same-edge writes count towards the verdict
  always_comb begin
    done_nx  = ch_done;
    any_fail = 1'b0;
    fch_nx   = '0;
    fcode_nx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      code_nx[i] = code[i];
      if (csr_we[i] && csr_wdata[32*i] && !ch_done[i]) begin
        done_nx[i] = 1'b1;
        code_nx[i] = csr_wdata[32*i+1 +: 31];
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!any_fail && code_nx[i] != 31'd0) begin
        any_fail = 1'b1;
        fch_nx   = FCH_W'(i);
        fcode_nx = code_nx[i];
      end
    end
    all_done = &done_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cycles    <= '0;
      ch_done   <= '0;
      fail_code <= '0;
      fail_ch   <= '0;
    end else begin
      case (state)
        S_RUN: begin
          cycles  <= cycles + CNT_W'(1);
          ch_done <= done_nx;
          if (all_done) begin
            if (any_fail) begin
              state     <= S_FAIL;
              fail_code <= fcode_nx;
              fail_ch   <= fch_nx;
            end else begin
              state <= S_PASS;
            end
          end else if (cycles == CYC_LAST) begin
            state <= S_TIMEOUT;
          end
        end
        default: begin
          if (start) begin
            state     <= S_RUN;
            cycles    <= '0;
            ch_done   <= '0;
            fail_code <= '0;
            fail_ch   <= '0;
          end
        end
      endcase
    end
  end

  // Stored codes are only consulted once a channel has completed in the current run
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (state != S_RUN && start)
        code[i] <= '0;
      else if (state == S_RUN)
        code[i] <= code_nx[i];
    end
  end

  assign busy      = (state == S_RUN);
  assign pass      = (state == S_PASS);
  assign timed_out = (state == S_TIMEOUT);
  assign done      = (state == S_PASS) || (state == S_FAIL) || (state == S_TIMEOUT);

endmodule

// File: tb/tb_test_status_monitor.sv
// Scoreboard bench for test_status_monitor: three instances cover 1, 2 and 4 channel builds.
module tb_test_status_monitor;

  typedef struct {
    logic        p;
    logic        t;
    logic [30:0] code;
    logic [3:0]  ch;
    logic [3:0]  cd;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t q4[$];

  // u1: NUM_CH=1
  logic        start1 = 0;
  logic [0:0]  we1 = '0;
  logic [31:0] wd1 = '0;
  logic        busy1, done1, pass1, to1;
  logic [30:0] fc1;
  logic [0:0]  fch1;
  logic [0:0]  cd1;
  logic [31:0] cyc1;
  test_status_monitor #(.NUM_CH(1), .TIMEOUT_CYCLES(2000), .CNT_W(32)) u1 (
    .clk(clk), .rst(rst), .start(start1), .csr_we(we1), .csr_wdata(wd1),
    .busy(busy1), .done(done1), .pass(pass1), .timed_out(to1),
    .fail_code(fc1), .fail_ch(fch1), .ch_done(cd1), .cycles(cyc1));

  // u2: NUM_CH=2, TIMEOUT_CYCLES=10
  logic        start2 = 0;
  logic [1:0]  we2 = '0;
  logic [63:0] wd2 = '0;
  logic        busy2, done2, pass2, to2;
  logic [30:0] fc2;
  logic [0:0]  fch2;
  logic [1:0]  cd2;
  logic [31:0] cyc2;
  test_status_monitor #(.NUM_CH(2), .TIMEOUT_CYCLES(10), .CNT_W(32)) u2 (
    .clk(clk), .rst(rst), .start(start2), .csr_we(we2), .csr_wdata(wd2),
    .busy(busy2), .done(done2), .pass(pass2), .timed_out(to2),
    .fail_code(fc2), .fail_ch(fch2), .ch_done(cd2), .cycles(cyc2));

  // u4: NUM_CH=4, TIMEOUT_CYCLES=100
  logic         start4 = 0;
  logic [3:0]   we4 = '0;
  logic [127:0] wd4 = '0;
  logic         busy4, done4, pass4, to4;
  logic [30:0]  fc4;
  logic [1:0]   fch4;
  logic [3:0]   cd4;
  logic [31:0]  cyc4;
  test_status_monitor #(.NUM_CH(4), .TIMEOUT_CYCLES(100), .CNT_W(32)) u4 (
    .clk(clk), .rst(rst), .start(start4), .csr_we(we4), .csr_wdata(wd4),
    .busy(busy4), .done(done4), .pass(pass4), .timed_out(to4),
    .fail_code(fc4), .fail_ch(fch4), .ch_done(cd4), .cycles(cyc4));

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk(input string tag, input exp_t e, input logic p, input logic t,
                     input logic [30:0] code, input logic [3:0] ch, input logic [3:0] cd,
                     input logic [31:0] cyc);
    cmp({tag, ".pass"}, 64'(p), 64'(e.p));
    cmp({tag, ".timed_out"}, 64'(t), 64'(e.t));
    cmp({tag, ".fail_code"}, 64'(code), 64'(e.code));
    cmp({tag, ".fail_ch"}, 64'(ch), 64'(e.ch));
    cmp({tag, ".ch_done"}, 64'(cd), 64'(e.cd));
    cmp({tag, ".cycles"}, 64'(cyc), 64'(e.cyc));
  endtask

  task automatic push(input int w, input logic p, input logic t, input logic [30:0] code,
                      input logic [3:0] ch, input logic [3:0] cd, input logic [31:0] cyc);
    exp_t e;
    e.p = p; e.t = t; e.code = code; e.ch = ch; e.cd = cd; e.cyc = cyc;
    case (w)
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q4.push_back(e);
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: one per instance, triggered on the rising edge of done
  logic done1_q = 0, done2_q = 0, done4_q = 0;
  always @(negedge clk) begin
    exp_t e;
    if (done1 && !done1_q) begin
      if (q1.size() == 0) cmp("u1.unexpected_done", 64'd1, 64'd0);
      else begin
        e = q1.pop_front();
        chk("u1", e, pass1, to1, fc1, {3'b0, fch1}, {3'b0, cd1}, cyc1);
      end
    end
    done1_q <= done1;
  end
  always @(negedge clk) begin
    exp_t e;
    if (done2 && !done2_q) begin
      if (q2.size() == 0) cmp("u2.unexpected_done", 64'd1, 64'd0);
      else begin
        e = q2.pop_front();
        chk("u2", e, pass2, to2, fc2, {3'b0, fch2}, {2'b0, cd2}, cyc2);
      end
    end
    done2_q <= done2;
  end
  always @(negedge clk) begin
    exp_t e;
    if (done4 && !done4_q) begin
      if (q4.size() == 0) cmp("u4.unexpected_done", 64'd1, 64'd0);
      else begin
        e = q4.pop_front();
        chk("u4", e, pass4, to4, fc4, {2'b0, fch4}, cd4, cyc4);
      end
    end
    done4_q <= done4;
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cmp("rst.busy", 64'(busy1), 64'd0);
    cmp("rst.done", 64'(done4), 64'd0);
    cmp("rst.cycles", 64'(cyc2), 64'd0);
    rst = 1'b0;

    // Writes before start are ignored
    we2 = 2'b11; wd2 = {32'h1, 32'h3};
    tick();
    we2 = '0;
    repeat (3) tick();
    cmp("idle.ch_done", 64'(cd2), 64'd0);
    cmp("idle.busy", 64'(busy1), 64'd0);

    // Completion on the 5th RUN edge
    push(1, 1, 0, 0, 0, 1, 5);
    start1 = 1; tick(); start1 = 0;
    cmp("s1.busy", 64'(busy1), 64'd1);
    cmp("s1.cycles0", 64'(cyc1), 64'd0);
    repeat (4) tick();
    cmp("s1.cycles4", 64'(cyc1), 64'd4);
    we1 = 1; wd1 = 32'h1; tick(); we1 = 0;
    tick();

    // Nonzero code gives FAIL
    push(1, 0, 0, 3, 0, 1, 1);
    start1 = 1; tick(); start1 = 0;
    we1 = 1; wd1 = 32'h7; tick(); we1 = 0;
    tick();

    // Four channels, ch2 and ch3 on the same edge
    push(4, 0, 0, 5, 2, 4'hF, 3);
    start4 = 1; tick(); start4 = 0;
    we4 = 4'b0001; wd4[31:0] = 32'h1; tick();
    we4 = 4'b0010; wd4[63:32] = 32'h1; tick();
    we4 = 4'b1100; wd4[95:64] = 32'hB; wd4[127:96] = 32'h1; tick();
    we4 = '0;
    tick();

    // All four on one edge, lowest failing index wins
    push(4, 0, 0, 2, 1, 4'hF, 1);
    start4 = 1; tick(); start4 = 0;
    we4 = 4'hF; wd4 = {32'h9, 32'h1, 32'h5, 32'h1}; tick();
    we4 = '0;
    tick();

    // Zero write ignored, repeat write ignored
    push(2, 1, 0, 0, 0, 3, 4);
    start2 = 1; tick(); start2 = 0;
    we2 = 2'b01; wd2 = {32'h0, 32'h0}; tick();
    wd2[31:0] = 32'h1; tick();
    wd2[31:0] = 32'h3; tick();
    we2 = '0;
    cmp("s5.ch_done", 64'(cd2), 64'd1);
    cmp("s5.busy", 64'(busy2), 64'd1);
    we2 = 2'b10; wd2[63:32] = 32'h1; tick();
    we2 = '0;
    tick();

    // Timeout after 10 RUN edges
    push(2, 0, 1, 0, 0, 1, 10);
    start2 = 1; tick(); start2 = 0;
    we2 = 2'b01; wd2 = {32'h0, 32'h1}; tick();
    we2 = '0;
    repeat (10) tick();
    cmp("s4.cycles_hold", 64'(cyc2), 64'd10);

    // Completion on the 10th edge beats timeout
    push(2, 1, 0, 0, 0, 3, 10);
    start2 = 1; tick(); start2 = 0;
    we2 = 2'b01; wd2 = {32'h0, 32'h1}; tick();
    we2 = '0;
    repeat (8) tick();
    we2 = 2'b10; wd2 = {32'h1, 32'h0}; tick();
    we2 = '0;
    tick();

    // Asynchronous reset mid-RUN
    start1 = 1; tick(); start1 = 0;
    repeat (3) tick();
    cmp("s6.cycles_pre", 64'(cyc1), 64'd3);
    #3 rst = 1'b1;
    #1;
    cmp("s6.busy", 64'(busy1), 64'd0);
    cmp("s6.cycles", 64'(cyc1), 64'd0);
    cmp("s6.ch_done4", 64'(cd4), 64'd0);
    cmp("s6.fail_code4", 64'(fc4), 64'd0);
    cmp("s6.done4", 64'(done4), 64'd0);
    cmp("s6.pass2", 64'(pass2), 64'd0);
    #1 rst = 1'b0;
    repeat (3) tick();
    cmp("s6.idle_busy", 64'(busy1), 64'd0);
    cmp("s6.idle_cycles", 64'(cyc1), 64'd0);
    push(1, 1, 0, 0, 0, 1, 3);
    start1 = 1; tick(); start1 = 0;
    repeat (2) tick();
    we1 = 1; wd1 = 32'h1; tick(); we1 = 0;

    repeat (5) tick();
    if (q1.size() != 0) cmp("q1.pending", 64'(q1.size()), 64'd0);
    if (q2.size() != 0) cmp("q2.pending", 64'(q2.size()), 64'd0);
    if (q4.size() != 0) cmp("q4.pending", 64'(q4.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
